// File: rtl/vend_scheduler_if.sv
// Panel/dispenser signal bundle for the two-panel vend scheduler.
// The master side drives requests and motor feedback; the slave side is the scheduler.
interface vend_scheduler_if;
    logic [1:0] req;
    logic [1:0] item0;
    logic [1:0] item1;
    logic [2:0] change0;
    logic [2:0] change1;
    logic       motor_done;
    logic       vend;
    logic [1:0] vend_item;
    logic       coin_out;
    logic [1:0] ack;
    logic       busy;
    logic       fault;

    modport master (
        output req, item0, item1, change0, change1, motor_done,
        input  vend, vend_item, coin_out, ack, busy, fault
    );

    modport slave (
        input  req, item0, item1, change0, change1, motor_done,
        output vend, vend_item, coin_out, ack, busy, fault
    );
endinterface

// File: rtl/vend_scheduler.sv
// Two-panel vending scheduler: arbitrates panel requests, commands the
// dispenser, waits for the motor with a timeout, pays out change coin by coin
// and acknowledges the served panel. A motor timeout locks into FAULT until reset.
module vend_scheduler #(
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    vend_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VEND   = 3'd1,
        S_WAIT   = 3'd2,
        S_CHANGE = 3'd3,
        S_DONE   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t     state_reg;
    logic [7:0] wait_cnt_reg;
    logic [2:0] change_reg;
    logic [2:0] remain_reg;
    logic [1:0] item_reg;
    logic       granted_reg;
    logic       last_served_reg;
    logic       vend_reg;
    logic       coin_out_reg;
    logic [1:0] ack_reg;
    logic       busy_reg;
    logic       fault_reg;

    // Per-panel views of the item/change buses so the grant can index them.
    logic [1:0] panel_item   [2];
    logic [2:0] panel_change [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_panel
            if (gi == 0) begin : g_p0
                assign panel_item[gi]   = bus.item0;
                assign panel_change[gi] = bus.change0;
            end else begin : g_p1
                assign panel_item[gi]   = bus.item1;
                assign panel_change[gi] = bus.change1;
            end
        end
    endgenerate

    // Arbitration: a lone request wins outright; on a tie the panel not served last wins.
    logic grant_idx;
    always_comb begin
        grant_idx = 1'b0;
        if (bus.req == 2'b11) begin
            grant_idx = ~last_served_reg;
        end else begin
            grant_idx = bus.req[1];
        end
    end

    // Main FSM; every output is a register updated alongside the state transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            wait_cnt_reg    <= 8'd0;
            change_reg      <= 3'd0;
            remain_reg      <= 3'd0;
            item_reg        <= 2'd0;
            granted_reg     <= 1'b0;
            last_served_reg <= 1'b1;
            vend_reg        <= 1'b0;
            coin_out_reg    <= 1'b0;
            ack_reg         <= 2'b00;
            busy_reg        <= 1'b0;
            fault_reg       <= 1'b0;
        end else begin
            vend_reg     <= 1'b0;
            coin_out_reg <= 1'b0;
            ack_reg      <= 2'b00;
            case (state_reg)
                S_IDLE: begin
                    if (|bus.req) begin
                        granted_reg <= grant_idx;
                        item_reg    <= panel_item[grant_idx];
                        change_reg  <= panel_change[grant_idx];
                        vend_reg    <= 1'b1;
                        busy_reg    <= 1'b1;
                        state_reg   <= S_VEND;
                    end
                end
                S_VEND: begin
                    wait_cnt_reg <= 8'd0;
                    state_reg    <= S_WAIT;
                end
                S_WAIT: begin
                    // Motor completion beats the timeout when both land together.
                    if (bus.motor_done) begin
                        if (change_reg != 3'd0) begin
                            remain_reg   <= change_reg;
                            coin_out_reg <= 1'b1;
                            state_reg    <= S_CHANGE;
                        end else begin
                            ack_reg[granted_reg] <= 1'b1;
                            state_reg            <= S_DONE;
                        end
                    end else if (wait_cnt_reg == TIMEOUT_LAST) begin
                        fault_reg <= 1'b1;
                        state_reg <= S_FAULT;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                S_CHANGE: begin
                    // Each cycle here is one coin; the last coin hands over to DONE.
                    remain_reg <= remain_reg - 3'd1;
                    if (remain_reg == 3'd1) begin
                        ack_reg[granted_reg] <= 1'b1;
                        state_reg            <= S_DONE;
                    end else begin
                        coin_out_reg <= 1'b1;
                    end
                end
                S_DONE: begin
                    last_served_reg <= granted_reg;
                    busy_reg        <= 1'b0;
                    state_reg       <= S_IDLE;
                end
                S_FAULT: begin
                    state_reg <= S_FAULT;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.vend      = vend_reg;
    assign bus.vend_item = item_reg;
    assign bus.coin_out  = coin_out_reg;
    assign bus.ack       = ack_reg;
    assign bus.busy      = busy_reg;
    assign bus.fault     = fault_reg;

endmodule
